// File: rtl/control_unit.sv
// Multi-cycle accumulator control unit: fetches from a registered-read ROM and executes
// against a small registered-read RAM. FAULT and HALT are terminal until reset.
module control_unit #(
  parameter int RAM_SIZE = 2,
  parameter int ROM_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ROM_SIZE-1:0] rom_addr,
  input  logic [15:0]         instr,
  output logic [RAM_SIZE-1:0] ram_addr,
  output logic                we,
  input  logic [15:0]         ram_out,
  output logic [15:0]         ram_in,
  output logic                fault,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_HALT   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0, OP_LDI = 4'h1, OP_LOAD = 4'h2, OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4, OP_SUB = 4'h5, OP_AND  = 4'h6, OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8, OP_JMP = 4'h9, OP_JZ   = 4'hA, OP_JC    = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC, OP_SHR = 4'hD, OP_HALT = 4'hF;

  state_t              state_q, state_d;
  logic [ROM_SIZE-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]         acc_q, acc_d;
  logic                z_q, z_d, c_q, c_d;
  logic [3:0]          op_q, op_d;
  logic [RAM_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]          op;
  logic [11:0]         imm;
  logic                mem_bad, jmp_bad, taken;
  logic [16:0]         wide;
  logic [15:0]         res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      acc_q      <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      op_q       <= OP_NOP;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      z_q        <= z_d;
      c_q        <= c_d;
      op_q       <= op_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    z_d        = z_q;
    c_d        = c_q;
    op_d       = op_q;
    ram_addr_d = ram_addr_q;
    we         = 1'b0;
    wide       = '0;
    res        = acc_q;
    op         = instr[15:12];
    imm        = instr[11:0];
    pc_inc     = pc_q + 1'b1;
    // Address bits beyond the memory's reach mean a malformed program, not a wrap.
    mem_bad    = (imm >> RAM_SIZE) != 12'd0;
    jmp_bad    = (imm >> ROM_SIZE) != 12'd0;
    taken      = (op == OP_JMP) || (op == OP_JZ && z_q) || (op == OP_JC && c_q);

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        op_d    = op;
        state_d = S_FETCH;
        case (op)
          OP_NOP: pc_d = pc_inc;
          OP_LDI: begin
            acc_d = {4'h0, imm};
            z_d   = (imm == 12'd0);
            pc_d  = pc_inc;
          end
          OP_SHL: begin
            acc_d = {acc_q[14:0], 1'b0};
            c_d   = acc_q[15];
            z_d   = (acc_q[14:0] == 15'd0);
            pc_d  = pc_inc;
          end
          OP_SHR: begin
            acc_d = {1'b0, acc_q[15:1]};
            c_d   = acc_q[0];
            z_d   = (acc_q[15:1] == 15'd0);
            pc_d  = pc_inc;
          end
          OP_JMP, OP_JZ, OP_JC: begin
            if (jmp_bad)    state_d = S_FAULT;
            else if (taken) pc_d = imm[ROM_SIZE-1:0];
            else            pc_d = pc_inc;
          end
          OP_STORE: begin
            if (mem_bad) state_d = S_FAULT;
            else begin
              we         = 1'b1;
              ram_addr_d = imm[RAM_SIZE-1:0];
              pc_d       = pc_inc;
            end
          end
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            if (mem_bad) state_d = S_FAULT;
            else begin
              ram_addr_d = imm[RAM_SIZE-1:0];
              state_d    = S_EXEC;
            end
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FAULT;
        endcase
      end

      S_EXEC: begin
        case (op_q)
          OP_LOAD: res = ram_out;
          OP_ADD: begin
            wide = {1'b0, acc_q} + {1'b0, ram_out};
            res  = wide[15:0];
            c_d  = wide[16];
          end
          OP_SUB: begin
            // Bit 16 of the widened difference is the borrow.
            wide = {1'b0, acc_q} - {1'b0, ram_out};
            res  = wide[15:0];
            c_d  = wide[16];
          end
          OP_AND:  res = acc_q & ram_out;
          OP_OR:   res = acc_q | ram_out;
          OP_XOR:  res = acc_q ^ ram_out;
          default: res = acc_q;
        endcase
        acc_d   = res;
        z_d     = (res == 16'd0);
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end

      default: state_d = state_q;
    endcase
  end

  // ram_addr is presented during DECODE so the registered RAM returns data in EXEC.
  assign ram_addr  = ram_addr_d;
  assign rom_addr  = pc_q;
  assign ram_in    = acc_q;
  assign fault     = (state_q == S_FAULT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with ROM/RAM models and a write-event scoreboard.
module tb_control_unit;
  localparam int RAM_SIZE = 2;
  localparam int ROM_SIZE = 8;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_HALT = 3'd3, S_FAULT = 3'd4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [ROM_SIZE-1:0] rom_addr;
  logic [15:0]         instr;
  logic [RAM_SIZE-1:0] ram_addr;
  logic                we;
  logic [15:0]         ram_out;
  logic [15:0]         ram_in;
  logic                fault;
  logic [2:0]          dbg_state;

  logic [15:0]         rom_mem [256];
  logic [15:0]         ram_mem [4];
  logic                poke_en = 1'b0;
  logic [1:0]          poke_addr = 2'd0;
  logic [15:0]         poke_data = 16'd0;

  logic [RAM_SIZE+15:0] exp_q [$];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  control_unit #(.RAM_SIZE(RAM_SIZE), .ROM_SIZE(ROM_SIZE)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .instr(instr),
    .ram_addr(ram_addr), .we(we), .ram_out(ram_out), .ram_in(ram_in),
    .fault(fault), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // ROM and RAM models: registered reads, synchronous write
  always @(posedge clk) begin
    instr   <= rom_mem[rom_addr];
    ram_out <= ram_mem[ram_addr];
    if (poke_en)  ram_mem[poke_addr] <= poke_data;
    else if (we)  ram_mem[ram_addr] <= ram_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr,data}
  always @(negedge clk) begin
    if (rst && we) begin
      check("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("we_event", 32'({ram_addr, ram_in}), 32'(exp_q.pop_front()));
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hF000;
  endtask

  task automatic poke(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic start();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_stop(input string tag, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (dbg_state == S_HALT || dbg_state == S_FAULT) begin
        done = 1'b1;
        break;
      end
    end
    check({"stop_", tag}, 32'(done), 32'd1);
  endtask

  initial begin
    // 1: reset state and fetch cadence
    clear_rom();
    rom_mem[0] = 16'h0000; rom_mem[1] = 16'h0000;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_in", 32'(ram_in), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_FETCH));
    rst = 1'b1;
    @(negedge clk);
    check("fetch0_state", 32'(dbg_state), 32'(S_DECODE));
    check("fetch0_addr", 32'(rom_addr), 32'h0);
    @(negedge clk);
    check("fetch1_state", 32'(dbg_state), 32'(S_FETCH));
    check("fetch1_addr", 32'(rom_addr), 32'h1);

    // 2: LDI/STORE/LOAD round trip; JZ not taken since Z=0
    clear_rom();
    rom_mem[0] = 16'h1123; rom_mem[1] = 16'h3002; rom_mem[2] = 16'h1000;
    rom_mem[3] = 16'h2002; rom_mem[4] = 16'hA010; rom_mem[5] = 16'hF000;
    exp_q.push_back({2'd2, 16'h0123});
    start();
    run_to_stop("t2", 100);
    check("t2_acc", 32'(ram_in), 32'h0123);
    check("t2_pc", 32'(rom_addr), 32'h5);
    check("t2_ram2", 32'(ram_mem[2]), 32'h0123);
    check("t2_writes", 32'(exp_q.size()), 32'd0);

    // 3: shifts, ADD wrapping to zero with carry; flags observed through JC then JZ
    clear_rom();
    rom_mem[0] = 16'h1FFF;
    for (int i = 1; i <= 4; i++) rom_mem[i] = 16'hC000;
    rom_mem[5] = 16'h3000; rom_mem[6] = 16'h1010; rom_mem[7] = 16'h4000;
    rom_mem[8] = 16'hB020; rom_mem[8'h20] = 16'hA030;
    exp_q.push_back({2'd0, 16'hFFF0});
    start();
    run_to_stop("t3", 100);
    check("t3_acc", 32'(ram_in), 32'h0000);
    check("t3_pc_cz", 32'(rom_addr), 32'h30);
    check("t3_writes", 32'(exp_q.size()), 32'd0);

    // SUB borrow, SHR, XOR/OR/AND with C unchanged by logic ops
    clear_rom();
    rom_mem[0] = 16'h1005; rom_mem[1] = 16'h3001; rom_mem[2] = 16'h1003;
    rom_mem[3] = 16'h5001; rom_mem[4] = 16'hB050;
    rom_mem[8'h50] = 16'hD000; rom_mem[8'h51] = 16'hB060; rom_mem[8'h52] = 16'h8001;
    rom_mem[8'h53] = 16'h3003; rom_mem[8'h54] = 16'h7001; rom_mem[8'h55] = 16'h6001;
    rom_mem[8'h56] = 16'hA070;
    exp_q.push_back({2'd1, 16'h0005});
    exp_q.push_back({2'd3, 16'h7FFA});
    start();
    run_to_stop("alu", 200);
    check("alu_acc", 32'(ram_in), 32'h0005);
    check("alu_pc", 32'(rom_addr), 32'h57);
    check("alu_writes", 32'(exp_q.size()), 32'd0);

    // 4: JZ taken / not taken, cycle exact
    clear_rom();
    rom_mem[0] = 16'h1000; rom_mem[1] = 16'hA040;
    start();
    repeat (4) @(negedge clk);
    check("jz_taken", 32'(rom_addr), 32'h40);
    check("jz_taken_state", 32'(dbg_state), 32'(S_FETCH));
    rom_mem[0] = 16'h1001;
    start();
    repeat (4) @(negedge clk);
    check("jz_not_taken", 32'(rom_addr), 32'h2);

    // 5: faults: illegal opcode, out-of-range LOAD/STORE/JMP
    clear_rom();
    rom_mem[0] = 16'hE000;
    start();
    run_to_stop("ill", 20);
    check("ill_fault", 32'(fault), 32'h1);
    repeat (5) @(negedge clk);
    check("ill_sticky", 32'(fault), 32'h1);
    check("ill_pc", 32'(rom_addr), 32'h0);
    rst = 1'b0;
    #1;
    check("ill_clear", 32'(fault), 32'h0);

    rom_mem[0] = 16'h1007; rom_mem[1] = 16'h2004;
    start();
    run_to_stop("ldbad", 20);
    repeat (3) @(negedge clk);
    check("ldbad_fault", 32'(fault), 32'h1);
    check("ldbad_pc", 32'(rom_addr), 32'h1);
    check("ldbad_acc", 32'(ram_in), 32'h0007);

    poke(2'd0, 16'hAAAA);
    clear_rom();
    rom_mem[0] = 16'h3004;
    start();
    run_to_stop("stbad", 20);
    check("stbad_fault", 32'(fault), 32'h1);
    check("stbad_ram0", 32'(ram_mem[0]), 32'hAAAA);

    rom_mem[0] = 16'h9100;
    start();
    run_to_stop("jmpbad", 20);
    check("jmpbad_fault", 32'(fault), 32'h1);
    check("jmpbad_pc", 32'(rom_addr), 32'h0);

    // 6: HALT freezes, resets abort EXEC and a pending STORE
    clear_rom();
    start();
    run_to_stop("halt", 20);
    repeat (4) @(negedge clk);
    check("halt_state", 32'(dbg_state), 32'(S_HALT));
    check("halt_pc", 32'(rom_addr), 32'h0);
    check("halt_fault", 32'(fault), 32'h0);

    rom_mem[0] = 16'h1055; rom_mem[1] = 16'h4000;
    start();
    repeat (4) @(negedge clk);
    check("exec_state", 32'(dbg_state), 32'(S_EXEC));
    check("exec_acc", 32'(ram_in), 32'h0055);
    rst = 1'b0;
    #1;
    check("exec_rst_pc", 32'(rom_addr), 32'h0);
    check("exec_rst_acc", 32'(ram_in), 32'h0);
    check("exec_rst_state", 32'(dbg_state), 32'(S_FETCH));

    poke(2'd1, 16'hBEEF);
    clear_rom();
    rom_mem[0] = 16'h1077; rom_mem[1] = 16'h3001;
    start();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    check("st_we_pending", 32'(we), 32'h1);
    check("st_addr_pending", 32'(ram_addr), 32'h1);
    rst = 1'b0;
    #1;
    check("st_we_cut", 32'(we), 32'h0);
    repeat (2) @(negedge clk);
    check("st_no_write", 32'(ram_mem[1]), 32'hBEEF);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
